// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the ALU issue controller, its watchdog
// and the testbench.
//   - ALU operation codes driven on alu_code (ALU_NOP when nothing is issued).
//   - alu_state_e: issue FSM state encoding, also used by bench monitors.
package alu_pkg;

  localparam logic [2:0] ALU_NOP = 3'h0;
  localparam logic [2:0] ALU_ADD = 3'h1;
  localparam logic [2:0] ALU_SUB = 3'h2;
  localparam logic [2:0] ALU_AND = 3'h3;
  localparam logic [2:0] ALU_OR  = 3'h4;
  localparam logic [2:0] ALU_XOR = 3'h5;
  localparam logic [2:0] ALU_SLL = 3'h6;
  localparam logic [2:0] ALU_SRL = 3'h7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_watchdog.sv
// alu_watchdog: down-counter bounding the time spent waiting for the ALU.
//   clk, rst_n  clock / asynchronous active-low reset
//   clr         reload the counter with TIMEOUT-1 (held while not waiting)
//   en          one count per cycle while waiting
//   expired     high during the TIMEOUT-th enabled cycle since the last clear
module alu_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (clr) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: requester side of the ALU interface, one operation in flight.
// Accepts an operation from decode (req_valid/req_ready), drives it onto the
// ALU until ready, then offers result + destination to writeback
// (wb_valid/wb_ready).
//   req_*            decode request: operands, alu code, destination register
//   op1/op2/alu_code registered drive to the ALU; alu_code is ALU_NOP when idle
//   ready/result     ALU response for the current operands
//   wb_*             writeback offer, held stable until wb_ready
//   err              sticky ALU timeout flag
// Optional feature macro: ALU_TIMEOUT_EN enables the ISSUE watchdog
// (alu_watchdog); without it the controller waits for the ALU indefinitely and
// err is tied low.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic [2:0]      req_code,
  input  logic [RD_W-1:0] req_rd,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [2:0]      alu_code,
  input  logic            ready,
  input  logic [XLEN-1:0] result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  alu_state_e      state_q;
  logic [XLEN-1:0] op1_q, op2_q, wb_data_q;
  logic [2:0]      code_q;
  logic [RD_W-1:0] rd_q;
  logic            first_q;   // first ISSUE cycle: ALU ready may be left over
  logic            wb_valid_q;

`ifdef ALU_TIMEOUT_EN
  logic err_q;
  logic wd_expired;

  alu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != ISSUE),
    .en      (state_q == ISSUE),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op1_q      <= '0;
      op2_q      <= '0;
      code_q     <= ALU_NOP;
      rd_q       <= '0;
      first_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
`ifdef ALU_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op1_q   <= req_op1;
            op2_q   <= req_op2;
            code_q  <= req_code;
            rd_q    <= req_rd;
            first_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          first_q <= 1'b0;
          if (!first_q && ready) begin
            wb_data_q  <= result;
            wb_valid_q <= 1'b1;
            code_q     <= ALU_NOP;
            state_q    <= WB;
          end
`ifdef ALU_TIMEOUT_EN
          else if (wd_expired) begin
            err_q      <= 1'b1;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b1;
            code_q     <= ALU_NOP;
            state_q    <= WB;
          end
`endif
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign alu_code  = code_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wb_data_q;
`ifdef ALU_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_op1, req_op2;
  logic [2:0]  req_code;
  logic [4:0]  req_rd;
  logic [31:0] op1, op2;
  logic [2:0]  alu_code;
  logic        ready;
  logic [31:0] result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  alu_issue_ctrl #(.XLEN(32), .RD_W(5), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_code  (req_code),
    .req_rd    (req_rd),
    .op1       (op1),
    .op2       (op2),
    .alu_code  (alu_code),
    .ready     (ready),
    .result    (result),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  code;
    logic [4:0]  rd;
    int          dly;    // ISSUE cycles with ready low before ready (>=1)
    int          stall;  // cycles wb_ready held low in WB
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Behavioural ALU standing in for the real one.
  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string nm);
    logic [31:0] a0, b0;
    logic [4:0]  rd0;
    a0 = v.a; b0 = v.b; rd0 = v.rd;
    chk({nm, ".req_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op1 = v.a; req_op2 = v.b; req_code = v.code; req_rd = v.rd;
    step();
    req_valid = 1'b0; req_op1 = 32'h0BAD_0BAD; req_op2 = 32'h0BAD_0BAD;
    chk({nm, ".req_ready_busy"}, {31'b0, req_ready}, 32'd0);
    chk({nm, ".op1"}, op1, a0);
    chk({nm, ".op2"}, op2, b0);
    chk({nm, ".alu_code"}, {29'b0, alu_code}, {29'b0, v.code});
    ready = 1'b0;
    repeat (v.dly) step();
    chk({nm, ".no_early_wb"}, {31'b0, wb_valid}, 32'd0);
    ready = 1'b1; result = alu_model(v.code, v.a, v.b);
    step();
    ready = 1'b0; result = 32'hDEAD_BEEF;
    chk({nm, ".wb_valid"}, {31'b0, wb_valid}, 32'd1);
    chk({nm, ".wb_data"}, wb_data, v.exp);
    chk({nm, ".wb_rd"}, {27'b0, wb_rd}, {27'b0, rd0});
    chk({nm, ".alu_nop"}, {29'b0, alu_code}, {29'b0, ALU_NOP});
    wb_ready = 1'b0;
    for (int i = 0; i < v.stall; i++) begin
      step();
      chk({nm, ".stall_valid"}, {31'b0, wb_valid}, 32'd1);
      chk({nm, ".stall_data"}, wb_data, v.exp);
      chk({nm, ".stall_rd"}, {27'b0, wb_rd}, {27'b0, rd0});
      chk({nm, ".stall_req_ready"}, {31'b0, req_ready}, 32'd0);
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk({nm, ".wb_done"}, {31'b0, wb_valid}, 32'd0);
    chk({nm, ".back_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op1 = '0; req_op2 = '0; req_code = '0; req_rd = '0;
    ready = 1'b0; result = '0; wb_ready = 1'b0;

    vecs[0] = '{a: 32'h0,        b: 32'h0,        code: 3'h1, rd: 5'd3,  dly: 1, stall: 0, exp: 32'h0};
    vecs[1] = '{a: 32'h40,       b: 32'h02,       code: 3'h1, rd: 5'd7,  dly: 1, stall: 3, exp: 32'h42};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 32'h1,        code: 3'h1, rd: 5'd31, dly: 3, stall: 1, exp: 32'h0};
    vecs[3] = '{a: 32'd10,       b: 32'd3,        code: 3'h2, rd: 5'd1,  dly: 2, stall: 0, exp: 32'd7};
    vecs[4] = '{a: 32'hF0F0,     b: 32'hFF00,     code: 3'h3, rd: 5'd16, dly: 1, stall: 2, exp: 32'hF000};
    vecs[5] = '{a: 32'hAAAA5555, b: 32'hFFFF0000, code: 3'h5, rd: 5'd0,  dly: 4, stall: 0, exp: 32'h55555555};

    // Reset values
    #12;
    chk("rst.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst.alu_code", {29'b0, alu_code}, 32'd0);
    chk("rst.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst.wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.err", {31'b0, err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-ISSUE
    req_valid = 1'b1; req_op1 = 32'h1234; req_op2 = 32'h1; req_code = ALU_ADD; req_rd = 5'd9;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_issue.req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_issue.alu_code", {29'b0, alu_code}, 32'd0);
    chk("rst_issue.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_issue.op1", op1, 32'd0);
    chk("rst_issue.err", {31'b0, err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Table-driven operations
    for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Stale ready held across the accept edge and first ISSUE cycle
    ready = 1'b1; result = 32'hDEAD_0001;
    req_valid = 1'b1; req_op1 = 32'h5; req_op2 = 32'h6; req_code = ALU_ADD; req_rd = 5'd12;
    step();
    req_valid = 1'b0;
    step();
    chk("stale.ignored", {31'b0, wb_valid}, 32'd0);
    result = 32'hB;
    step();
    ready = 1'b0;
    chk("stale.captured_valid", {31'b0, wb_valid}, 32'd1);
    chk("stale.captured_data", wb_data, 32'hB);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // wb_ready asserted early, req_valid held with new operands while busy
    wb_ready = 1'b1;
    req_valid = 1'b1; req_op1 = 32'h100; req_op2 = 32'h23; req_code = ALU_ADD; req_rd = 5'd4;
    step();
    wb_ready = 1'b0;
    req_op1 = 32'h777; req_op2 = 32'h888; req_code = ALU_SUB; req_rd = 5'd22;
    step();
    chk("hold.op1_issue", op1, 32'h100);
    ready = 1'b1; result = 32'h123;
    step();
    ready = 1'b0;
    chk("hold.wb_data", wb_data, 32'h123);
    chk("hold.wb_rd", {27'b0, wb_rd}, 32'd4);
    chk("hold.op2_wb", op2, 32'h23);
    chk("hold.no_accept_wb", {31'b0, req_ready}, 32'd0);
    step();
    chk("hold.early_wb_ready_no_effect", {31'b0, wb_valid}, 32'd1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("hold.idle_again", {31'b0, req_ready}, 32'd1);
    chk("hold.not_yet_taken", op1, 32'h100);
    step();
    req_valid = 1'b0;
    chk("hold.second_op1", op1, 32'h777);
    chk("hold.second_code", {29'b0, alu_code}, {29'b0, ALU_SUB});
    step();
    ready = 1'b1; result = 32'hFFFF_FF11;
    step();
    ready = 1'b0;
    chk("hold.second_rd", {27'b0, wb_rd}, 32'd22);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

`ifdef ALU_TIMEOUT_EN
    // Watchdog: ALU never answers
    req_valid = 1'b1; req_op1 = 32'h9; req_op2 = 32'h9; req_code = ALU_ADD; req_rd = 5'd5;
    step();
    req_valid = 1'b0;
    repeat (15) step();
    chk("to.not_yet", {31'b0, wb_valid}, 32'd0);
    step();
    chk("to.wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("to.wb_data", wb_data, 32'd0);
    chk("to.err", {31'b0, err}, 32'd1);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    run_op(vecs[1], "to_after");
    chk("to.err_sticky", {31'b0, err}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("to.err_cleared", {31'b0, err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
`else
    // No watchdog: a silent ALU stalls ISSUE indefinitely
    req_valid = 1'b1; req_op1 = 32'h9; req_op2 = 32'h9; req_code = ALU_ADD; req_rd = 5'd5;
    step();
    req_valid = 1'b0;
    repeat (24) step();
    chk("nowd.still_waiting", {31'b0, wb_valid}, 32'd0);
    chk("nowd.err", {31'b0, err}, 32'd0);
    ready = 1'b1; result = 32'h12;
    step();
    ready = 1'b0;
    chk("nowd.late_result", wb_data, 32'h12);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
`endif

    // Reset mid-WB drops the result
    req_valid = 1'b1; req_op1 = 32'h1; req_op2 = 32'h2; req_code = ALU_ADD; req_rd = 5'd8;
    step();
    req_valid = 1'b0;
    step();
    ready = 1'b1; result = 32'h3;
    step();
    ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_wb.wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb.wb_data", wb_data, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
